// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch instruction queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC         = 32'h0001_0000;
    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam int          FQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_q_mem.sv
// Fetch queue storage: two writes to consecutive slots per push, two async reads.
module fetch_q_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata0_i,
    input  logic [W-1:0]             wdata1_i,
    input  logic [$clog2(DEPTH)-1:0] raddr0_i,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [W-1:0]             rdata0_o,
    output logic [W-1:0]             rdata1_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] waddr1;

    // Second slot of the pair wraps with the AW-bit address.
    assign waddr1 = waddr_i + AW'(1);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata0_i;
            mem_q[waddr1]  <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_inst_queue.sv
// Dual-issue fetch queue: pair push, 0..2 pop, first-word fall-through outputs.
// Optional stall-cycle counter enabled by defining FETCH_Q_PERF_EN.
module fetch_inst_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int XLEN  = fetch_pkg::XLEN,
    parameter int ILEN  = fetch_pkg::ILEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    input  logic [XLEN-1:0]            pc1_i,
    input  logic [ILEN-1:0]            instr1_i,
    input  logic [XLEN-1:0]            pc2_i,
    input  logic [ILEN-1:0]            instr2_i,
    input  logic [1:0]                 pop_cnt_i,
    output logic [1:0]                 out_valid_o,
    output logic [XLEN-1:0]            out_pc1_o,
    output logic [ILEN-1:0]            out_instr1_o,
    output logic [XLEN-1:0]            out_pc2_o,
    output logic [ILEN-1:0]            out_instr2_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [31:0]                perf_stall_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = XLEN + ILEN;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_ptr1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pop_req, eff_pop;
    logic             stall, push_acc;
    logic [EW-1:0]    rdata0, rdata1;

    // Fewer than two free slots; depends on registered occupancy only.
    assign stall    = count_q > CNT_W'(DEPTH - 2);
    assign push_acc = push_valid_i && !stall && !flush_i;
    assign rd_ptr1  = rd_ptr_q + AW'(1);

    always_comb begin
        pop_req = (pop_cnt_i == 2'd3) ? CNT_W'(2) : CNT_W'(pop_cnt_i);
        eff_pop = (pop_req > count_q) ? count_q : pop_req;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(2);
            end
            rd_ptr_d = rd_ptr_q + eff_pop[AW-1:0];
            count_d  = count_q + (push_acc ? CNT_W'(2) : CNT_W'(0)) - eff_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_q_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk      (clk),
        .we_i     (push_acc),
        .waddr_i  (wr_ptr_q),
        .wdata0_i ({pc1_i, instr1_i}),
        .wdata1_i ({pc2_i, instr2_i}),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr1),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    assign out_valid_o  = {count_q >= CNT_W'(2), count_q != '0};
    assign out_pc1_o    = out_valid_o[0] ? rdata0[EW-1:ILEN]  : '0;
    assign out_instr1_o = out_valid_o[0] ? rdata0[ILEN-1:0]   : '0;
    assign out_pc2_o    = out_valid_o[1] ? rdata1[EW-1:ILEN]  : '0;
    assign out_instr2_o = out_valid_o[1] ? rdata1[ILEN-1:0]   : '0;
    assign stall_o      = stall;
    assign count_o      = count_q;

`ifdef FETCH_Q_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating; flush does not clear it, only reset does.
    always_comb begin
        perf_d = perf_q;
        if (push_valid_i && stall && !flush_i && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = 32'h0;
`endif

endmodule
